// File: rtl/ex_div_seq_if.sv
// ex_div_seq_if: request/response bundle between the Ex stage and the
// multi-cycle divide sequencer.
//
// Handshake: Ex raises start_i with operands and signed_i valid, and holds
// start_i high until it has consumed result_o. The divider raises ready_o
// when result_o is valid and keeps it high while start_i stays high. Ex
// drops start_i for at least one cycle before issuing the next divide.
// annul_i flushes an in-flight divide, and no result is produced.
//
// Signals:
//   start_i    divide request (Ex -> divider)
//   annul_i    cancel in-flight divide (Ex -> divider)
//   signed_i   1 = signed, 0 = unsigned (Ex -> divider)
//   opdata1_i  dividend (Ex -> divider)
//   opdata2_i  divisor (Ex -> divider)
//   result_o   {remainder, quotient} (divider -> Ex)
//   ready_o    result_o valid (divider -> Ex)
//   busy_o     divide in progress (divider -> Ex)
interface ex_div_seq_if #(
  parameter int DATA_W = 32
);
  logic                start_i;
  logic                annul_i;
  logic                signed_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                busy_o;

  modport master (
    output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/ex_div_seq.sv
// ex_div_seq: multi-cycle radix-2 restoring integer divider for the Ex stage.
// Produces one quotient bit per cycle and returns {remainder, quotient}.
//
// Optional feature macro: DIV_EARLY_OUT_EN. When defined, a divide whose
// dividend magnitude is below the divisor magnitude skips the iterations
// and completes through the short (divide-by-zero) path with quotient 0 and
// remainder = original dividend. Results are identical either way.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, highest priority
//   bus          ex_div_seq_if.slave (request/response bundle)
//   dbg_state_o  current FSM state (0 IDLE, 1 DIVZERO, 2 ON, 3 END)
//
// Latency (start sampled at edge t): busy_o rises after edge t. A normal
// divide raises ready_o after edge t+DATA_W, and a divide by zero (or an
// early-out divide) raises it after edge t+1.
module ex_div_seq #(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_div_seq_if.slave bus,
  output logic [1:0]  dbg_state_o
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   dvs_q;      // divisor magnitude
  logic [DATA_W-1:0]   rem_q;      // partial remainder
  logic [DATA_W-1:0]   quo_q;      // dividend bits shifting out / quotient in
  logic [CW-1:0]       cnt_q;
  logic                quo_neg_q;  // negate quotient at the end
  logic                rem_neg_q;  // negate remainder at the end
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;
  logic                busy_q;

  // Operand magnitudes at capture time
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              early_hit;

  always_comb begin
    a_neg = bus.signed_i & bus.opdata1_i[DATA_W-1];
    b_neg = bus.signed_i & bus.opdata2_i[DATA_W-1];
    a_mag = a_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    b_mag = b_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
`ifdef DIV_EARLY_OUT_EN
    early_hit = (bus.opdata2_i != '0) && (a_mag < b_mag);
`else
    early_hit = 1'b0;
`endif
  end

  // One restoring step. rem_sh needs DATA_W+1 bits because the remainder
  // before the shift can be as large as divisor-1. The top bit of diff is
  // the borrow, and it is clear exactly when rem_sh >= divisor.
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;
  logic              ge;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W-1:0] quo_nx;
  logic [DATA_W-1:0] rem_fin;
  logic [DATA_W-1:0] quo_fin;

  always_comb begin
    rem_sh  = {rem_q, quo_q[DATA_W-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    ge      = ~diff[DATA_W];
    rem_nx  = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quo_nx  = {quo_q[DATA_W-2:0], ge};
    rem_fin = rem_neg_q ? (~rem_nx + 1'b1) : rem_nx;
    quo_fin = quo_neg_q ? (~quo_nx + 1'b1) : quo_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          busy_q   <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            quo_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dvs_q     <= b_mag;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if ((bus.opdata2_i == '0) || early_hit) begin
              // The short path reports {rem_q, quo_q} directly, so preload
              // it with the final answer: zero for a zero divisor, or the
              // untouched dividend for an early-out.
              state_q <= S_DIVZERO;
              rem_q   <= early_hit ? bus.opdata1_i : '0;
              quo_q   <= '0;
            end else begin
              state_q <= S_ON;
              rem_q   <= '0;
              quo_q   <= a_mag;
            end
          end
        end

        S_DIVZERO: begin
          state_q  <= S_END;
          result_q <= {rem_q, quo_q};
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end

        S_ON: begin
          if (bus.annul_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_W - 1)) begin
              state_q  <= S_END;
              result_q <= {rem_fin, quo_fin};
              ready_q  <= 1'b1;
              busy_q   <= 1'b0;
            end
          end
        end

        S_END: begin
          if (!bus.start_i) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_ex_div_seq.sv
// tb_ex_div_seq: directed self-checking bench for ex_div_seq (DATA_W=32).
// Inputs change on the falling edge. Outputs are sampled 1 time unit after
// the rising edge. Latencies are counted in rising edges after the edge that
// samples start_i: 32 for a full divide and 1 for the short path.
module tb_ex_div_seq;
  localparam int W = 32;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  ex_div_seq_if #(.DATA_W(W)) dif ();

  ex_div_seq #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (dif),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 32;
`endif

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    dif.start_i   = 1'b0;
    dif.annul_i   = 1'b0;
    dif.signed_i  = 1'b0;
    dif.opdata1_i = '0;
    dif.opdata2_i = '0;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    @(negedge clk);
    dif.start_i   = 1'b1;
    dif.annul_i   = 1'b0;
    dif.signed_i  = sgn;
    dif.opdata1_i = a;
    dif.opdata2_i = b;
  endtask

  // Waits for the sampling edge t, then counts further edges until ready_o.
  // lat = -1 on timeout. busy_cnt counts samples with busy_o high before ready.
  task automatic wait_ready(output int lat, output int busy_cnt);
    bit done;
    done     = 1'b0;
    busy_cnt = 0;
    lat      = -1;
    @(posedge clk); #1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (dif.ready_o) begin
        lat  = i;
        done = 1'b1;
      end else begin
        if (dif.busy_o) busy_cnt++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic release_start();
    @(negedge clk);
    dif.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dif.ready_o !== 1'b0 || dif.busy_o !== 1'b0 || dif.result_o !== 64'h0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b busy=%b result=%h state=%0d, required 0/0/0/0",
               dif.ready_o, dif.busy_o, dif.result_o, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat, bc;
    issue(32'd100, 32'd7, 1'b0);
    wait_ready(lat, bc);
    n_checks++;
    if (lat !== 32) begin
      n_fail++; $display("FAIL u100_7_latency: got %0d required 32", lat);
    end
    n_checks++;
    if (bc !== 32) begin
      n_fail++; $display("FAIL u100_7_busy_cycles: got %0d required 32", bc);
    end
    n_checks++;
    if (dif.result_o !== {32'h2, 32'hE} || dif.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL u100_7_result: got %h busy=%b required %h busy=0",
                         dif.result_o, dif.busy_o, {32'h2, 32'hE});
    end
    release_start();

    // Same bit pattern as -7, treated as unsigned
    issue(32'hFFFF_FFF9, 32'h2, 1'b0);
    wait_ready(lat, bc);
    n_checks++;
    if (lat !== 32 || dif.result_o !== {32'h1, 32'h7FFF_FFFC}) begin
      n_fail++; $display("FAIL uFFFFFFF9_2: lat=%0d result=%h required lat=32 result=%h",
                         lat, dif.result_o, {32'h1, 32'h7FFF_FFFC});
    end
    release_start();
  endtask

  task automatic test_signed();
    int lat, bc;
    issue(32'hFFFF_FFF9, 32'h2, 1'b1);        // -7 / 2 = -3 r -1
    wait_ready(lat, bc);
    n_checks++;
    if (lat !== 32 || dif.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_fail++; $display("FAIL s_m7_2: lat=%0d result=%h required lat=32 result=%h",
                         lat, dif.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    release_start();

    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); // most-negative / -1
    wait_ready(lat, bc);
    n_checks++;
    if (lat !== 32 || dif.result_o !== {32'h0, 32'h8000_0000}) begin
      n_fail++; $display("FAIL s_minneg_m1: lat=%0d result=%h required lat=32 result=%h",
                         lat, dif.result_o, {32'h0, 32'h8000_0000});
    end
    release_start();

    issue(32'd7, 32'hFFFF_FFFE, 1'b1);         // 7 / -2 = -3 r 1
    wait_ready(lat, bc);
    n_checks++;
    if (lat !== 32 || dif.result_o !== {32'h1, 32'hFFFF_FFFD}) begin
      n_fail++; $display("FAIL s_7_m2: lat=%0d result=%h required lat=32 result=%h",
                         lat, dif.result_o, {32'h1, 32'hFFFF_FFFD});
    end
    release_start();
  endtask

  task automatic test_divzero_hold();
    int lat, bc;
    issue(32'd5, 32'd0, 1'b0);
    wait_ready(lat, bc);
    n_checks++;
    if (lat !== 1 || bc !== 1) begin
      n_fail++; $display("FAIL divzero_latency: lat=%0d busy=%0d required lat=1 busy=1", lat, bc);
    end
    n_checks++;
    if (dif.result_o !== 64'h0) begin
      n_fail++; $display("FAIL divzero_result: got %h required 0", dif.result_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dif.ready_o !== 1'b1 || dif.result_o !== 64'h0 || dif.busy_o !== 1'b0) begin
        n_fail++; $display("FAIL divzero_hold%0d: ready=%b busy=%b result=%h required 1/0/0",
                           i, dif.ready_o, dif.busy_o, dif.result_o);
      end
    end
    release_start();
    n_checks++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'h0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL divzero_release: ready=%b result=%h state=%0d required 0/0/0",
                         dif.ready_o, dif.result_o, dbg_state);
    end

    // Release after a real result must also clear result_o
    issue(32'd100, 32'd7, 1'b0);
    wait_ready(lat, bc);
    release_start();
    n_checks++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'h0) begin
      n_fail++; $display("FAIL result_clear: ready=%b result=%h required 0/0",
                         dif.ready_o, dif.result_o);
    end
  endtask

  task automatic test_annul();
    int lat, bc;
    bit saw_ready;
    saw_ready = 1'b0;
    issue(32'd1000, 32'd3, 1'b0);
    @(posedge clk);                     // edge t
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (dif.ready_o) saw_ready = 1'b1;
    end
    @(negedge clk);
    dif.annul_i = 1'b1;
    @(posedge clk); #1;                 // edge t+10
    n_checks++;
    if (dif.busy_o !== 1'b0 || dif.ready_o !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL annul_idle: busy=%b ready=%b state=%0d required 0/0/0",
                         dif.busy_o, dif.ready_o, dbg_state);
    end
    @(negedge clk);
    dif.opdata1_i = 32'd9;
    dif.opdata2_i = 32'd4;
    @(posedge clk); #1;                 // edge t+11, annul still high
    if (dif.ready_o || dif.busy_o) saw_ready = 1'b1;
    n_checks++;
    if (saw_ready !== 1'b0) begin
      n_fail++; $display("FAIL annul_no_result: ready/busy seen=%b required 0", saw_ready);
    end
    @(negedge clk);
    dif.annul_i = 1'b0;
    wait_ready(lat, bc);                // sampled at edge t+12
    n_checks++;
    if (lat !== 32 || dif.result_o !== {32'h1, 32'h2}) begin
      n_fail++; $display("FAIL annul_then_9_4: lat=%0d result=%h required lat=32 result=%h",
                         lat, dif.result_o, {32'h1, 32'h2});
    end
    release_start();
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    issue(32'd1000, 32'd3, 1'b0);
    @(posedge clk);                     // edge t
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;                 // edge t+20
    n_checks++;
    if (dif.ready_o !== 1'b0 || dif.busy_o !== 1'b0 || dif.result_o !== 64'h0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_mid: ready=%b busy=%b result=%h state=%0d required all 0",
                         dif.ready_o, dif.busy_o, dif.result_o, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    dif.start_i = 1'b0;
    @(posedge clk);
    issue(32'd6, 32'd3, 1'b0);
    wait_ready(lat, bc);
    n_checks++;
    if (lat !== 32 || dif.result_o !== {32'h0, 32'h2}) begin
      n_fail++; $display("FAIL reset_then_6_3: lat=%0d result=%h required lat=32 result=%h",
                         lat, dif.result_o, {32'h0, 32'h2});
    end
    release_start();
  endtask

  task automatic test_small_dividend();
    int lat, bc;
    issue(32'd3, 32'd10, 1'b0);
    wait_ready(lat, bc);
    n_checks++;
    if (lat !== SMALL_LAT || dif.result_o !== {32'h3, 32'h0}) begin
      n_fail++; $display("FAIL u3_10: lat=%0d result=%h required lat=%0d result=%h",
                         lat, dif.result_o, SMALL_LAT, {32'h3, 32'h0});
    end
    release_start();

    issue(32'hFFFF_FFFD, 32'd10, 1'b1);       // -3 / 10 = 0 r -3
    wait_ready(lat, bc);
    n_checks++;
    if (lat !== SMALL_LAT || dif.result_o !== {32'hFFFF_FFFD, 32'h0}) begin
      n_fail++; $display("FAIL s_m3_10: lat=%0d result=%h required lat=%0d result=%h",
                         lat, dif.result_o, SMALL_LAT, {32'hFFFF_FFFD, 32'h0});
    end
    release_start();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero_hold();
    test_annul();
    test_reset_mid();
    test_small_dividend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
